// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-source round-robin arbiter feeding a byte-wide UART
// transmitter. Each frame pops one byte from the granted FIFO, hands it to
// the transmitter with a one-cycle tx_start, follows the transmitter's busy
// flag high then low, and optionally idles GAP_CYCLES cycles before the
// next arbitration.
//
// Handshake: fX_rd is a one-cycle read strobe and the FIFO presents the byte
// on fX_dout in the following cycle; tx_start is a one-cycle request that the
// transmitter acknowledges by raising tx_busy and completes by dropping it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            permits new arbitration (a running frame completes)
//   f0_empty/f0_rd/f0_dout  source-0 FIFO
//   f1_empty/f1_rd/f1_dout  source-1 FIFO
//   tx_busy           transmitter busy
//   tx_start, tx_data request and byte to the transmitter
//   active_src        source of the current/last granted byte
//   ctrl_busy         high whenever the FSM is not IDLE
//   sent_cnt          number of tx_start pulses issued (wraps)
//   dbg_state         current FSM state encoding
module uart_tx_arb #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        f0_empty,
    output logic        f0_rd,
    input  logic [7:0]  f0_dout,
    input  logic        f1_empty,
    output logic        f1_rd,
    input  logic [7:0]  f1_dout,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        active_src,
    output logic        ctrl_busy,
    output logic [15:0] sent_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LATCH   = 3'd2,
        START   = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        GAP     = 3'd6
    } state_t;

    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

    state_t     state;
    logic       last_src;
    logic [7:0] gap_cnt;

    logic want0;
    logic want1;
    logic grant;
    logic can_go;

    // Round-robin: on a tie the source that did not win last time is granted.
    always_comb begin
        want0  = !f0_empty;
        want1  = !f1_empty;
        grant  = (want0 && want1) ? !last_src : want1;
        can_go = enable && !tx_busy && (want0 || want1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            f0_rd      <= 1'b0;
            f1_rd      <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            active_src <= 1'b0;
            ctrl_busy  <= 1'b0;
            sent_cnt   <= 16'h0000;
            last_src   <= 1'b1;
            gap_cnt    <= 8'h00;
        end else begin
            // Strobes are single-cycle; they are re-asserted only by the
            // transition that enters READ or START.
            f0_rd    <= 1'b0;
            f1_rd    <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_go) begin
                        state      <= READ;
                        active_src <= grant;
                        last_src   <= grant;
                        f0_rd      <= !grant;
                        f1_rd      <= grant;
                        ctrl_busy  <= 1'b1;
                    end
                end
                READ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    tx_data  <= active_src ? f1_dout : f0_dout;
                    tx_start <= 1'b1;
                    state    <= START;
                end
                START: begin
                    sent_cnt <= sent_cnt + 16'd1;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (GAP_CYCLES == 0) begin
                            state     <= IDLE;
                            ctrl_busy <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_INIT;
                        end
                    end
                end
                GAP: begin
                    // Counter holds the number of GAP cycles still to spend,
                    // including the current one.
                    if (gap_cnt <= 8'd1) begin
                        state     <= IDLE;
                        ctrl_busy <= 1'b0;
                        gap_cnt   <= 8'h00;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ctrl_busy <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
